memory_stream_reader: RTL and testbench
=======================================

// Module: memory_stream_reader
// PURPOSE
// Sits directly downstream of single_port_memory. It drives that memory's address
// port and converts its combinational read data into a valid/ready beat stream.
// A start command gives a base address and a beat count. The block reads that many
// consecutive words, wrapping modulo DataDepth, and delivers them in order through
// a 2-entry output FIFO. It sustains 1 beat/cycle and never drops data under
// backpressure.
// PARAMETERS
// DataWidth  128                 width of one memory word / stream beat
// DataDepth  64                  number of memory words; address wraps modulo this value
// AddrWidth  clog2(DataDepth)    address width (1 if DataDepth<=1)
// LenWidth   AddrWidth+1         beat-count width (0..DataDepth beats)
// PORTS
// clk_i          in   1          clock, all logic on rising edge
// rst_i          in   1          synchronous active-high reset
// start_i        in   1          command strobe; sampled only in IDLE
// base_addr_i    in   AddrWidth  first word address, sampled with start_i
// len_i          in   LenWidth   beat count, sampled with start_i
// busy_o         out  1          high while a command is in progress
// done_o         out  1          1-cycle pulse, command complete
// mem_addr_o     out  AddrWidth  address to memory
// mem_we_o       out  1          memory write enable; constant 0
// mem_rd_data_i  in   DataWidth  combinational read data for mem_addr_o
// out_data_o     out  DataWidth  stream data = FIFO head
// out_valid_o    out  1          FIFO non-empty
// out_ready_i    in   1          consumer accepts beat when valid&&ready
// BEHAVIOUR
// - Reset, and all outputs after reset: state=IDLE, FIFO empty, counters 0.
//   busy_o=0, done_o=0, out_valid_o=0, mem_addr_o=0, mem_we_o=0.
//   out_data_o is don't-care while out_valid_o=0.
// - FSM states: IDLE, RUN, DONE.
// - IDLE -> RUN: start_i=1 && len_i!=0. Latch addr_q=base_addr_i, issue_cnt=len_i,
//   pop_cnt=len_i.
// - IDLE -> DONE: start_i=1 && len_i==0. No memory reads, no beats.
// - RUN -> DONE: in the cycle the last beat is popped (pop_cnt==1 && valid && ready).
// - DONE -> IDLE: always, after one cycle. done_o=1 only in DONE.
// - busy_o=1 in RUN.
// - start_i outside IDLE is ignored; it is not queued.
// - mem_addr_o = addr_q at all times.
// - Issue condition, evaluated in RUN: issue_cnt!=0 && (fifo_cnt<2 || (out_valid_o && out_ready_i)).
//   On issue: push mem_rd_data_i into the FIFO at the edge,
//   addr_q <= (addr_q==DataDepth-1) ? 0 : addr_q+1, and issue_cnt--.
// - Pop: out_valid_o && out_ready_i. Pop frees FIFO head and decrements pop_cnt.
// - A simultaneous push and pop on a full FIFO is legal; occupancy stays 2.
// - FIFO occupancy never exceeds 2; out_data_o order equals address order.
// - Latency: start accepted at edge of cycle 0. mem_addr_o=base in cycle 1.
//   First out_valid_o in cycle 2. With out_ready_i held high, beats occur in
//   cycles 2..len+1 and done_o is in cycle len+2.
// - Memory content must not change while busy_o=1; the block does not check this.
// - out_data_o/out_valid_o change only after a pop or a push, never while
//   valid&&!ready (AXI-stream-style hold rule).
// - rst_i mid-command: abort immediately. FIFO is flushed and no done_o pulse is
//   produced; next cycle behaves as after reset.
// - len_i==DataDepth: reads the full memory once, wrapping back to base.
// TESTING
// 1. Mem[i]=i. start base=10 len=4, ready=1 -> mem_addr_o 10,11,12,13 in cycles 1-4.
//    Beats 10,11,12,13 in cycles 2-5; done_o only in cycle 6; busy_o cycles 1-5.
// 2. Wrap: base=62 len=4 DataDepth=64 -> beats 62,63,0,1, then done_o.
// 3. Backpressure: base=0 len=6, ready low in cycles 3-7 ->
//    occupancy<=2, mem_addr_o stalls at 3, out_data_o held stable while stalled.
//    All 6 beats 0..5 arrive in order, with exactly 6 handshakes.
// 4. len=0 -> done_o in cycle 1, out_valid_o never asserted, busy_o stays 0.
// 5. start_i pulsed in cycle 3 of a len=8 command -> ignored.
//    Exactly 8 beats and one done_o.
// 6. rst_i in cycle 4 of a len=8 command -> cycle 5: out_valid_o=0, busy_o=0, done_o=0.
//    A new start then completes normally.
// - Bench also checks: mem_we_o==0 always; random ready toggling gives
//   beats == len with no duplicates.

Source files
------------

// File: rtl/memory_stream_reader_if.sv
// Bundles the command, memory and output-stream signals of memory_stream_reader.
// Signal suffixes are written from the reader's point of view.
interface memory_stream_reader_if #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned DataDepth = 64,
    parameter int unsigned AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
    parameter int unsigned LenWidth  = AddrWidth + 1
);
    // Command side
    logic                 start_i;
    logic [AddrWidth-1:0] base_addr_i;
    logic [LenWidth-1:0]  len_i;
    logic                 busy_o;
    logic                 done_o;
    // Memory side
    logic [AddrWidth-1:0] mem_addr_o;
    logic                 mem_we_o;
    logic [DataWidth-1:0] mem_rd_data_i;
    // Output stream
    logic [DataWidth-1:0] out_data_o;
    logic                 out_valid_o;
    logic                 out_ready_i;

    // Reader view
    modport master (
        input  start_i, base_addr_i, len_i, mem_rd_data_i, out_ready_i,
        output busy_o, done_o, mem_addr_o, mem_we_o, out_data_o, out_valid_o
    );

    // Environment view: command source, memory and stream consumer
    modport slave (
        output start_i, base_addr_i, len_i, mem_rd_data_i, out_ready_i,
        input  busy_o, done_o, mem_addr_o, mem_we_o, out_data_o, out_valid_o
    );
endinterface

// File: rtl/memory_stream_reader.sv
// Reads len consecutive words (wrapping modulo DataDepth) from a combinational-read
// memory and streams them out through a 2-entry FIFO at up to one beat per cycle.
module memory_stream_reader #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned DataDepth = 64,
    parameter int unsigned AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
    parameter int unsigned LenWidth  = AddrWidth + 1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    memory_stream_reader_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(DataDepth - 1);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LenWidth-1:0]  pop_cnt_q, pop_cnt_d;
    logic [DataWidth-1:0] fifo_q [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           fifo_cnt_q, fifo_cnt_d;
    logic                 push;
    logic                 pop;

    // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO can still accept
    always_comb begin
        pop  = (fifo_cnt_q != 2'd0) && bus.out_ready_i;
        push = (state_q == StRun) && (issue_cnt_q != '0) && ((fifo_cnt_q < 2'd2) || pop);
    end

    // Next-state logic for the FSM, address/beat counters and FIFO pointers
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    if (bus.len_i != '0) begin
                        state_d     = StRun;
                        addr_d      = bus.base_addr_i;
                        issue_cnt_d = bus.len_i;
                        pop_cnt_d   = bus.len_i;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (push) begin
                    addr_d      = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                end
                if (pop) begin
                    pop_cnt_d = pop_cnt_q - 1'b1;
                    if (pop_cnt_q == LenWidth'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State registers; FIFO storage is not reset since it is only visible while valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.mem_rd_data_i;
            end
        end
    end

    assign bus.busy_o      = (state_q == StRun);
    assign bus.done_o      = (state_q == StDone);
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_we_o    = 1'b0;
    assign bus.out_valid_o = (fifo_cnt_q != 2'd0);
    assign bus.out_data_o  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed bench for memory_stream_reader with a beat scoreboard.
module tb_memory_stream_reader;
    localparam int unsigned DW = 128;
    localparam int unsigned DD = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned LW = 7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_stream_reader_if #(.DataWidth(DW), .DataDepth(DD), .AddrWidth(AW), .LenWidth(LW)) bus ();

    memory_stream_reader #(
        .DataWidth(DW),
        .DataDepth(DD),
        .AddrWidth(AW),
        .LenWidth (LW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [DW-1:0] mem [DD];
    assign bus.mem_rd_data_i = mem[bus.mem_addr_o];

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [DW-1:0] exp_q [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a command for one cycle and queues the beats it must produce
    task automatic start_cmd(input int base, input int len);
        bus.start_i     = 1'b1;
        bus.base_addr_i = AW'(base);
        bus.len_i       = LW'(len);
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(DW'((base + k) % DD));
        end
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!bus.done_o && n < limit) begin
            tick();
            n++;
        end
        chk("done_seen", DW'(bus.done_o), DW'(1));
    endtask

    // Monitor: scoreboard on handshakes, hold rule on stalls, write enable always low
    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_we", DW'(bus.mem_we_o), DW'(0));
            if (prev_stall) begin
                chk("hold_valid", DW'(bus.out_valid_o), DW'(1));
                chk("hold_data", bus.out_data_o, prev_data);
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                hs_cnt++;
                chk("beat_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    chk("beat_data", bus.out_data_o, exp_q.pop_front());
                end
            end
            if (bus.done_o) begin
                done_cnt++;
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_data  = bus.out_data_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int dn0;
        for (int i = 0; i < int'(DD); i++) begin
            mem[i] = DW'(i);
        end
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.len_i       = '0;
        bus.out_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", DW'(bus.busy_o), DW'(0));
        chk("rst_done", DW'(bus.done_o), DW'(0));
        chk("rst_valid", DW'(bus.out_valid_o), DW'(0));
        chk("rst_addr", DW'(bus.mem_addr_o), DW'(0));
        chk("rst_we", DW'(bus.mem_we_o), DW'(0));
        tick();

        // 1: base 10, len 4, cycle-exact timing
        start_cmd(10, 4);
        for (int c = 1; c <= 5; c++) begin
            chk("t1_busy", DW'(bus.busy_o), DW'(1));
            chk("t1_done", DW'(bus.done_o), DW'(0));
            if (c <= 4) chk("t1_addr", DW'(bus.mem_addr_o), DW'(9 + c));
            if (c == 1) begin
                chk("t1_valid_c1", DW'(bus.out_valid_o), DW'(0));
            end else begin
                chk("t1_valid", DW'(bus.out_valid_o), DW'(1));
                chk("t1_data", bus.out_data_o, DW'(8 + c));
            end
            tick();
        end
        chk("t1_done_c6", DW'(bus.done_o), DW'(1));
        chk("t1_busy_c6", DW'(bus.busy_o), DW'(0));
        chk("t1_valid_c6", DW'(bus.out_valid_o), DW'(0));
        tick();
        chk("t1_done_c7", DW'(bus.done_o), DW'(0));
        chk("t1_sb_empty", DW'(exp_q.size()), DW'(0));

        // 2: wrap at the top of memory
        hs0 = hs_cnt;
        start_cmd(62, 4);
        wait_done(20);
        chk("t2_beats", DW'(hs_cnt - hs0), DW'(4));
        chk("t2_sb_empty", DW'(exp_q.size()), DW'(0));
        tick();

        // 3: backpressure in cycles 3-7
        hs0 = hs_cnt;
        start_cmd(0, 6);
        tick();
        tick();
        bus.out_ready_i = 1'b0;
        chk("t3_data_c3", bus.out_data_o, DW'(1));
        tick();
        for (int c = 4; c <= 7; c++) begin
            chk("t3_addr_stall", DW'(bus.mem_addr_o), DW'(3));
            chk("t3_valid_stall", DW'(bus.out_valid_o), DW'(1));
            chk("t3_data_stall", bus.out_data_o, DW'(1));
            tick();
        end
        bus.out_ready_i = 1'b1;
        wait_done(20);
        chk("t3_beats", DW'(hs_cnt - hs0), DW'(6));
        chk("t3_sb_empty", DW'(exp_q.size()), DW'(0));
        tick();

        // 4: zero-length command
        hs0 = hs_cnt;
        start_cmd(5, 0);
        chk("t4_done_c1", DW'(bus.done_o), DW'(1));
        chk("t4_busy_c1", DW'(bus.busy_o), DW'(0));
        chk("t4_valid_c1", DW'(bus.out_valid_o), DW'(0));
        tick();
        chk("t4_done_c2", DW'(bus.done_o), DW'(0));
        chk("t4_busy_c2", DW'(bus.busy_o), DW'(0));
        chk("t4_beats", DW'(hs_cnt - hs0), DW'(0));

        // 5: start while busy is ignored
        hs0 = hs_cnt;
        dn0 = done_cnt;
        start_cmd(20, 8);
        tick();
        tick();
        bus.start_i     = 1'b1;
        bus.base_addr_i = AW'(5);
        bus.len_i       = LW'(3);
        tick();
        bus.start_i = 1'b0;
        wait_done(30);
        tick();
        tick();
        tick();
        chk("t5_beats", DW'(hs_cnt - hs0), DW'(8));
        chk("t5_dones", DW'(done_cnt - dn0), DW'(1));
        chk("t5_sb_empty", DW'(exp_q.size()), DW'(0));

        // 6: reset mid-command, then a fresh command
        hs0 = hs_cnt;
        dn0 = done_cnt;
        start_cmd(30, 8);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", DW'(bus.out_valid_o), DW'(0));
        chk("t6_busy", DW'(bus.busy_o), DW'(0));
        chk("t6_done", DW'(bus.done_o), DW'(0));
        chk("t6_beats_pre", DW'(hs_cnt - hs0), DW'(2));
        exp_q.delete();
        tick();
        chk("t6_no_done", DW'(done_cnt - dn0), DW'(0));
        hs0 = hs_cnt;
        start_cmd(40, 5);
        wait_done(20);
        chk("t6_beats_post", DW'(hs_cnt - hs0), DW'(5));
        chk("t6_sb_empty", DW'(exp_q.size()), DW'(0));
        tick();

        // 7: random ready with wrap and full-depth read
        hs0 = hs_cnt;
        start_cmd(50, 20);
        for (int n = 0; n < 300 && !bus.done_o; n++) begin
            bus.out_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.out_ready_i = 1'b1;
        chk("t7_done", DW'(bus.done_o), DW'(1));
        chk("t7_beats", DW'(hs_cnt - hs0), DW'(20));
        chk("t7_sb_empty", DW'(exp_q.size()), DW'(0));
        tick();

        hs0 = hs_cnt;
        start_cmd(7, 64);
        for (int n = 0; n < 400 && !bus.done_o; n++) begin
            bus.out_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.out_ready_i = 1'b1;
        chk("t8_done", DW'(bus.done_o), DW'(1));
        chk("t8_beats", DW'(hs_cnt - hs0), DW'(64));
        chk("t8_sb_empty", DW'(exp_q.size()), DW'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
